ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter/sequencer for the single-port 256x8 synchronous block RAM (clka/ena/wea/addra/dina/douta, 1-cycle read latency).
- Each requester issues read/write commands over a req/gnt handshake and receives read data with a valid strobe.
- Optionally zero-fills the RAM after reset before accepting traffic.
- Sits between the RAM_CG macro and the two datapath clients.

---
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-requester round-robin arbiter and sequencer in front of a single-port
// synchronous block RAM with a read latency of one cycle.
// Each requester issues commands over a REQ/GNT handshake. GNT is
// combinational, and a command transfers on any rising edge where REQ and GNT
// are both high. Read data returns on DOUTx with a one-cycle DVALIDx pulse,
// two cycles after the grant edge.
//
// Optional feature (macro RAM_ARB_CLEAR_EN): after every reset the RAM is
// filled with CLEAR_VAL, one word per cycle. READY stays low and no grants
// are issued until the fill is complete.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   REQx/WEx/ADDRx/DINx  requester x command (x = 0, 1)
//   GNTx              requester x command accepted this cycle
//   DVALIDx/DOUTx     requester x read data and its valid strobe
//   RAM_EN/RAM_WE/RAM_ADDR/RAM_DIN   registered RAM command
//   RAM_DOUT          RAM read data, valid the cycle after a read reaches it
//   READY             high while accepting traffic
module ram_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [DATA_W-1:0] DIN0,
   output logic              GNT0,
   output logic              DVALID0,
   output logic [DATA_W-1:0] DOUT0,
   input  logic              REQ1,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] DIN1,
   output logic              GNT1,
   output logic              DVALID1,
   output logic [DATA_W-1:0] DOUT1,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_DIN,
   input  logic [DATA_W-1:0] RAM_DOUT,
   output logic              READY
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e state_q, state_d;
   logic ready_q, ready_d;
   logic last_q, last_d;
   logic ramEn_q, ramEn_d;
   logic ramWe_q, ramWe_d;
   logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
   logic [DATA_W-1:0] ramDin_q, ramDin_d;
   logic rd1_q, rd1_d;
   logic tag1_q, tag1_d;
   logic rd2_q;
   logic tag2_q;
   logic dvalid0_q, dvalid1_q;
   logic [DATA_W-1:0] dout0_q, dout1_q;
   logic xfer;
   logic owner;

`ifdef RAM_ARB_CLEAR_EN
   logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
   // The fill value only matters when the clear feature is built in.
   logic unusedClearVal;
   assign unusedClearVal = ^CLEAR_VAL;
`endif

   // Arbitration. A port that requests alone always wins. On a tie the port
   // that was not granted most recently wins.
   assign GNT0 = ready_q & REQ0 & (~REQ1 | last_q);
   assign GNT1 = ready_q & REQ1 & (~REQ0 | ~last_q);
   assign xfer  = GNT0 | GNT1;
   assign owner = GNT1;

   // Next-state logic. During the clear the command stage writes CLEAR_VAL to
   // successive addresses. During RUN it takes the granted command, or goes
   // idle. Every read carries its owner tag down a two-stage pipeline, which
   // lines up with the RAM read latency.
   always_comb begin
      state_d   = state_q;
      last_d    = xfer ? owner : last_q;
      ramEn_d   = 1'b0;
      ramWe_d   = 1'b0;
      ramAddr_d = ramAddr_q;
      ramDin_d  = ramDin_q;
      rd1_d     = 1'b0;
      tag1_d    = owner;
`ifdef RAM_ARB_CLEAR_EN
      cnt_d     = cnt_q;
      if (state_q == ST_CLEAR) begin
         ramEn_d   = 1'b1;
         ramWe_d   = 1'b1;
         ramAddr_d = cnt_q;
         ramDin_d  = CLEAR_VAL;
         cnt_d     = cnt_q + 1'b1;
         if (cnt_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
`endif
      if (xfer) begin
         ramEn_d   = 1'b1;
         ramWe_d   = owner ? WE1 : WE0;
         ramAddr_d = owner ? ADDR1 : ADDR0;
         ramDin_d  = owner ? DIN1 : DIN0;
         rd1_d     = owner ? ~WE1 : ~WE0;
      end
      ready_d = (state_d == ST_RUN);
   end

   // State and pipeline registers. On reset the in-flight reads are flushed
   // and the round-robin pointer is set so that port 0 wins the first tie.
   always_ff @(posedge CLK) begin
      if (RST) begin
`ifdef RAM_ARB_CLEAR_EN
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
`else
         state_q <= ST_RUN;
`endif
         ready_q   <= 1'b0;
         last_q    <= 1'b1;
         ramEn_q   <= 1'b0;
         ramWe_q   <= 1'b0;
         ramAddr_q <= '0;
         ramDin_q  <= '0;
         rd1_q     <= 1'b0;
         tag1_q    <= 1'b0;
         rd2_q     <= 1'b0;
         tag2_q    <= 1'b0;
         dvalid0_q <= 1'b0;
         dvalid1_q <= 1'b0;
         dout0_q   <= '0;
         dout1_q   <= '0;
      end else begin
         state_q <= state_d;
`ifdef RAM_ARB_CLEAR_EN
         cnt_q   <= cnt_d;
`endif
         ready_q   <= ready_d;
         last_q    <= last_d;
         ramEn_q   <= ramEn_d;
         ramWe_q   <= ramWe_d;
         ramAddr_q <= ramAddr_d;
         ramDin_q  <= ramDin_d;
         rd1_q     <= rd1_d;
         tag1_q    <= tag1_d;
         rd2_q     <= rd1_q;
         tag2_q    <= tag1_q;
         dvalid0_q <= rd2_q & ~tag2_q;
         dvalid1_q <= rd2_q & tag2_q;
         if (rd2_q & ~tag2_q) begin
            dout0_q <= RAM_DOUT;
         end
         if (rd2_q & tag2_q) begin
            dout1_q <= RAM_DOUT;
         end
      end
   end

   assign READY    = ready_q;
   assign RAM_EN   = ramEn_q;
   assign RAM_WE   = ramWe_q;
   assign RAM_ADDR = ramAddr_q;
   assign RAM_DIN  = ramDin_q;
   assign DVALID0  = dvalid0_q;
   assign DVALID1  = dvalid1_q;
   assign DOUT0    = dout0_q;
   assign DOUT1    = dout1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed testbench for ram_arbiter. It includes a behavioural 256x8
// single-port RAM with one-cycle read latency. Inputs are driven on the
// falling edge. Combinational grants are sampled 1 ns later, and registered
// outputs are sampled on the falling edge.
module tb_ram_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
   logic [7:0] ADDR0 = '0, DIN0 = '0, ADDR1 = '0, DIN1 = '0;
   logic       GNT0, GNT1, DVALID0, DVALID1;
   logic [7:0] DOUT0, DOUT1;
   logic       RAM_EN, RAM_WE, READY;
   logic [7:0] RAM_ADDR, RAM_DIN;
   logic [7:0] RAM_DOUT = '0;
   logic [7:0] mem [256];

   int checks = 0;
   int failures = 0;

   ram_arbiter dut (
      .CLK(CLK), .RST(RST),
      .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .DIN0(DIN0),
      .GNT0(GNT0), .DVALID0(DVALID0), .DOUT0(DOUT0),
      .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .DIN1(DIN1),
      .GNT1(GNT1), .DVALID1(DVALID1), .DOUT1(DOUT1),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
      .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT), .READY(READY)
   );

   // Free-running clock with a 10 ns period.
   always #5 CLK = ~CLK;

   // Behavioural block RAM. The read is read-first with one-cycle latency.
   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
         RAM_DOUT <= mem[RAM_ADDR];
      end
   end

   // Drives both requester command buses.
   task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                                input logic [7:0] d0, input logic r1, input logic w1,
                                input logic [7:0] a1, input logic [7:0] d1);
      REQ0 = r0; WE0 = w0; ADDR0 = a0; DIN0 = d0;
      REQ1 = r1; WE1 = w1; ADDR1 = a1; DIN1 = d1;
   endtask

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits, with a cycle bound, for READY after a reset and checks that no
   // read data shows up meanwhile.
   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (READY !== 1'b1 && n < 300) begin
         checkOutput({tag, "_nodv"}, {DVALID0, DVALID1}, 2'b00);
         @(negedge CLK);
         n++;
      end
      checkOutput({tag, "_ready"}, READY, 1'b1);
   endtask

   // Directed test sequence.
   initial begin
      int j;
      logic [7:0] rdAddr [4];
      logic [7:0] rdData [4];
      rdAddr[0] = 8'h01; rdAddr[1] = 8'h02; rdAddr[2] = 8'h10; rdAddr[3] = 8'h01;
      rdData[0] = 8'h11; rdData[1] = 8'h22; rdData[2] = 8'hA5; rdData[3] = 8'h11;

      // Reset state. The request is held to show that no grant is issued.
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge CLK); @(negedge CLK);
      checkOutput("rst_ready", READY, 1'b0);
      checkOutput("rst_gnt0", GNT0, 1'b0);
      checkOutput("rst_ramen", {RAM_EN, RAM_WE}, 2'b00);
      checkOutput("rst_addr_din", {RAM_ADDR, RAM_DIN}, 16'h0000);
      checkOutput("rst_dv", {DVALID0, DVALID1}, 2'b00);
      checkOutput("rst_dout", {DOUT0, DOUT1}, 16'h0000);
      RST = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
      // Clear phase: each cycle writes the next address with zero.
      for (int i = 0; i < 256; i++) begin
         @(negedge CLK);
         checkOutput("clr_cmd", {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}, {2'b11, i[7:0], 8'h00});
         checkOutput("clr_ready", READY, (i == 255));
         if (i < 255) checkOutput("clr_gnt0", GNT0, 1'b0);
         if (i == 254) REQ0 = 1'b0;
      end
`else
      REQ0 = 1'b0;
      @(negedge CLK);
      checkOutput("run_ready_first", READY, 1'b1);
`endif
      @(negedge CLK);
      checkOutput("idle_no_we", {RAM_EN, RAM_WE}, 2'b00);

      // Port 0 writes 0x10=A5, then reads it back.
      applyStimulus(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
      #1 checkOutput("wr_gnt", {GNT0, GNT1}, 2'b10);
      @(negedge CLK);
      checkOutput("wr_cmd", {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}, {2'b11, 8'h10, 8'hA5});
      applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      #1 checkOutput("rd_gnt", {GNT0, GNT1}, 2'b10);
      @(negedge CLK);
      checkOutput("rd_cmd", {RAM_EN, RAM_WE, RAM_ADDR}, {2'b10, 8'h10});
      REQ0 = 1'b0;
      @(negedge CLK);
      checkOutput("rd_dv_early", DVALID0, 1'b0);
      @(negedge CLK);
      checkOutput("rd_dv", {DVALID0, DVALID1}, 2'b10);
      checkOutput("rd_data", DOUT0, 8'hA5);
      @(negedge CLK);
      checkOutput("rd_dv_pulse", DVALID0, 1'b0);
      checkOutput("rd_hold", DOUT0, 8'hA5);

      // Port 1 preloads 0x01=11 and 0x02=22.
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 8'h11);
      #1 checkOutput("pre_gnt_a", {GNT0, GNT1}, 2'b01);
      @(negedge CLK);
      ADDR1 = 8'h02; DIN1 = 8'h22;
      #1 checkOutput("pre_gnt_b", {GNT0, GNT1}, 2'b01);
      @(negedge CLK);
      REQ1 = 1'b0;
      @(negedge CLK);

      // Both ports read continuously. Grants and returns alternate.
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      for (int k = 0; k < 10; k++) begin
         if (k == 6) begin REQ0 = 1'b0; REQ1 = 1'b0; end
         #1;
         checkOutput("rr_gnt", {GNT0, GNT1}, (k < 6) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
         j = k - 3;
         checkOutput("rr_dv", {DVALID0, DVALID1},
                     (j >= 0 && j < 6) ? ((j % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
         if (j >= 0 && j < 6 && j % 2 == 0) checkOutput("rr_dout0", DOUT0, 8'h11);
         if (j >= 0 && j < 6 && j % 2 == 1) checkOutput("rr_dout1", DOUT1, 8'h22);
         @(negedge CLK);
      end

      // Only port 1 issues back-to-back reads. The data returns in order.
      for (int k = 0; k < 7; k++) begin
         if (k < 4) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, rdAddr[k], 8'h00);
         else REQ1 = 1'b0;
         #1;
         checkOutput("p1_gnt", {GNT0, GNT1}, (k < 4) ? 2'b01 : 2'b00);
         j = k - 3;
         checkOutput("p1_dv", {DVALID0, DVALID1}, (j >= 0) ? 2'b01 : 2'b00);
         if (j >= 0) checkOutput("p1_dout", DOUT1, rdData[j]);
         @(negedge CLK);
      end
      @(negedge CLK);

      // A read is in flight when reset hits. It is dropped, and the pointer
      // is reset, although port 0 was the most recent winner.
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      #1 checkOutput("fl_gnt", GNT0, 1'b1);
      @(negedge CLK);
      REQ0 = 1'b0; RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("fl_ready", READY, 1'b0);
      checkOutput("fl_ram", {RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}, 18'h0);
      checkOutput("fl_dout", {DOUT0, DOUT1}, 16'h0000);
      checkOutput("fl_dv", {DVALID0, DVALID1}, 2'b00);
      @(negedge CLK);
      checkOutput("fl_dv_late", {DVALID0, DVALID1}, 2'b00);
      waitReady("fl");
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      #1 checkOutput("fl_tie", {GNT0, GNT1}, 2'b10);
      @(negedge CLK);
      REQ0 = 1'b0; REQ1 = 1'b0;
      @(negedge CLK); @(negedge CLK);
      checkOutput("fl_tie_dv", {DVALID0, DVALID1}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
